// File: rtl/ln_pkg.sv
// rtl/ln_pkg.sv - saturation limits, floor-shift/clip helpers and default multiplier latency for ln_norm_affine_pipe
package ln_pkg;

    localparam int LN_LAT_DEF = 5;
    localparam int LN_DW_DEF  = 16;

    function automatic longint sat_hi(input int dw);
        return (longint'(1) <<< (dw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    localparam longint LN_SAT_HI_DEF = sat_hi(LN_DW_DEF);
    localparam longint LN_SAT_LO_DEF = sat_lo(LN_DW_DEF);

    // Arithmetic right shift, i.e. floor division by 2^sh for negative values too.
    function automatic longint floor_shr(input longint v, input int sh);
        return v >>> sh;
    endfunction

    function automatic longint sat_clip(input longint t, input int dw);
        if (t > sat_hi(dw)) begin
            return sat_hi(dw);
        end else if (t < sat_lo(dw)) begin
            return sat_lo(dw);
        end
        return t;
    endfunction

endpackage

// File: rtl/ln_affine_lane.sv
// rtl/ln_affine_lane.sv - one lane of y = sat(((x - mean) * inv_sqrt >>> FRAC) * gamma >>> FRAC + beta), stalled by i_adv
// Optional LN_SAT_CNT_EN adds a per-lane saturation flag aligned with o_y.
module ln_affine_lane
    import ln_pkg::*;
#(
    parameter int DW       = 16,
    parameter int FRAC     = 10,
    parameter int LAT_MUL1 = LN_LAT_DEF,
    parameter int LAT_MUL2 = LN_LAT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_adv,
    input  logic                 i_rms_mode,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_mean,
    input  logic signed [DW:0]   i_inv_sqrt,
    input  logic signed [DW-1:0] i_gamma,
    input  logic signed [DW-1:0] i_beta,
    output logic signed [DW-1:0] o_y
`ifdef LN_SAT_CNT_EN
    ,
    output logic                 o_sat
`endif
);

    localparam int PW1 = 2 * DW + 2;
    localparam int PW2 = PW1 + DW;
    localparam int GD  = 1 + LAT_MUL1;
    localparam int BD  = 1 + LAT_MUL1 + LAT_MUL2;

    logic signed [DW-1:0]  mean_eff;
    logic signed [DW:0]    s_d, s_q, inv_d, inv_q;
    logic signed [PW1-1:0] p1_d [LAT_MUL1];
    logic signed [PW1-1:0] p1_q [LAT_MUL1];
    logic signed [PW1-1:0] n;
    logic signed [PW2-1:0] p2_d [LAT_MUL2];
    logic signed [PW2-1:0] p2_q [LAT_MUL2];
    logic signed [DW-1:0]  gamma_d [GD];
    logic signed [DW-1:0]  gamma_q [GD];
    logic signed [DW-1:0]  beta_d [BD];
    logic signed [DW-1:0]  beta_q [BD];
    logic signed [63:0]    t_l;
    logic signed [DW-1:0]  y_d, y_q;
`ifdef LN_SAT_CNT_EN
    logic signed [63:0]    y_l;
    logic                  sat_d, sat_q;
`endif

    always_comb begin
        mean_eff = i_rms_mode ? '0 : i_mean;
        s_d      = {i_x[DW-1], i_x} - {mean_eff[DW-1], mean_eff};
        inv_d    = i_inv_sqrt;

        p1_d[0] = s_q * inv_q;
        for (int k = 1; k < LAT_MUL1; k++) begin
            p1_d[k] = p1_q[k-1];
        end

        n       = PW1'(floor_shr(longint'(p1_q[LAT_MUL1-1]), FRAC));
        p2_d[0] = n * gamma_q[GD-1];
        for (int k = 1; k < LAT_MUL2; k++) begin
            p2_d[k] = p2_q[k-1];
        end

        // gamma/beta ride alongside the product so they meet it at the right stage
        gamma_d[0] = i_gamma;
        for (int k = 1; k < GD; k++) begin
            gamma_d[k] = gamma_q[k-1];
        end
        beta_d[0] = i_beta;
        for (int k = 1; k < BD; k++) begin
            beta_d[k] = beta_q[k-1];
        end

        t_l = floor_shr(longint'(p2_q[LAT_MUL2-1]), FRAC) + longint'(beta_q[BD-1]);
`ifdef LN_SAT_CNT_EN
        y_l   = sat_clip(t_l, DW);
        y_d   = y_l[DW-1:0];
        sat_d = (y_l != t_l);
`else
        y_d   = DW'(sat_clip(t_l, DW));
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_adv) begin
            s_q     <= s_d;
            inv_q   <= inv_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            gamma_q <= gamma_d;
            beta_q  <= beta_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            y_q <= '0;
`ifdef LN_SAT_CNT_EN
            sat_q <= 1'b0;
`endif
        end else if (i_adv) begin
            y_q <= y_d;
`ifdef LN_SAT_CNT_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign o_y = y_q;
`ifdef LN_SAT_CNT_EN
    assign o_sat = sat_q;
`endif

endmodule

// File: rtl/ln_norm_affine_pipe.sv
// rtl/ln_norm_affine_pipe.sv - N_LANES LayerNorm/RMSNorm normalize+affine pipeline with valid/ready backpressure
// Optional LN_SAT_CNT_EN adds o_sat_cnt, a saturating count of saturated lanes in delivered beats.
module ln_norm_affine_pipe
    import ln_pkg::*;
#(
    parameter int N_LANES  = 64,
    parameter int DW       = 16,
    parameter int FRAC     = 10,
    parameter int ADDR_W   = 6,
    parameter int LAT_MUL1 = LN_LAT_DEF,
    parameter int LAT_MUL2 = LN_LAT_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_rms_mode,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [31:0]             i_mean,
    input  logic [DW:0]             i_inv_sqrt,
    input  logic [N_LANES*DW-1:0]   i_raw_flat,
    input  logic [N_LANES*DW-1:0]   i_gamma_flat,
    input  logic [N_LANES*DW-1:0]   i_beta_flat,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [ADDR_W-1:0]       o_addr,
    output logic [N_LANES*DW-1:0]   o_data_flat
`ifdef LN_SAT_CNT_EN
    ,
    output logic [31:0]             o_sat_cnt
`endif
);

    localparam int D = 2 + LAT_MUL1 + LAT_MUL2;

    logic              adv;
    logic [D-1:0]      vld_d, vld_q;
    logic [ADDR_W-1:0] addr_d [D];
    logic [ADDR_W-1:0] addr_q [D];
    logic              unused_mean_hi;

    assign unused_mean_hi = ^i_mean[31:DW];

    // The whole pipe freezes when the output beat is held; bubbles drain only by advancing.
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    always_comb begin
        vld_d     = {vld_q[D-2:0], i_valid && adv};
        addr_d[0] = i_addr;
        for (int k = 1; k < D; k++) begin
            addr_d[k] = addr_q[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < D; k++) begin
                addr_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign o_valid = vld_q[D-1];
    assign o_addr  = addr_q[D-1];

`ifdef LN_SAT_CNT_EN
    logic [N_LANES-1:0] sat_vec;
    logic [32:0]        sat_sum;
    logic [31:0]        sat_cnt_d, sat_cnt_q;
`endif

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        ln_affine_lane #(
            .DW       (DW),
            .FRAC     (FRAC),
            .LAT_MUL1 (LAT_MUL1),
            .LAT_MUL2 (LAT_MUL2)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_adv      (adv),
            .i_rms_mode (i_rms_mode),
            .i_x        (i_raw_flat[DW*g +: DW]),
            .i_mean     (i_mean[DW-1:0]),
            .i_inv_sqrt (i_inv_sqrt),
            .i_gamma    (i_gamma_flat[DW*g +: DW]),
            .i_beta     (i_beta_flat[DW*g +: DW]),
            .o_y        (o_data_flat[DW*g +: DW])
`ifdef LN_SAT_CNT_EN
            ,
            .o_sat      (sat_vec[g])
`endif
        );
    end

`ifdef LN_SAT_CNT_EN
    // One overflow bit is enough: a single beat adds at most N_LANES.
    always_comb begin
        sat_sum = {1'b0, sat_cnt_q};
        for (int i = 0; i < N_LANES; i++) begin
            sat_sum = sat_sum + 33'(sat_vec[i]);
        end
        sat_cnt_d = sat_cnt_q;
        if (o_valid && i_ready) begin
            sat_cnt_d = sat_sum[32] ? '1 : sat_sum[31:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`endif

endmodule
